polyveck_reduce_stream: RTL

Streaming, parametrised successor to the combinational polyveck conditional-add-q block. It accepts a K-polynomial vector as a stream of LANES signed coefficients per beat and applies a per-vector selectable reduction: caddq, reduce32, freeze (reduce32 then caddq), or pass. It sits between NTT/arithmetic stages and the packers, uses valid/ready handshakes on both sides, and tags its output with polynomial index and last-beat markers.

---
 rtl/polyveck_reduce_stream.sv | 139 +++++++++++++
 1 files changed

// File: rtl/polyveck_reduce_stream.sv
// Streaming polynomial-vector reducer: a two-stage valid/ready pipeline applying
// caddq, reduce32, freeze (reduce32 then caddq) or pass to LANES coefficients per beat.
module polyveck_reduce_stream #(
  parameter int K       = 6,
  parameter int N       = 256,
  parameter int LANES   = 8,
  parameter int COEFF_W = 32,
  parameter int Q       = 8380417,
  localparam int IDX_W  = (K > 1) ? $clog2(K) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               cfg_mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*COEFF_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*COEFF_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_poly_idx,
  output logic                     out_last,
  output logic                     done
);

  localparam int BPP    = N / LANES;
  localparam int BEAT_W = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int DW     = LANES * COEFF_W;

  localparam logic [COEFF_W-1:0]        QW    = COEFF_W'(Q);
  localparam logic signed [COEFF_W:0]   ROUND = (COEFF_W + 1)'(1 << 22);

  typedef enum logic [1:0] {
    MODE_CADDQ    = 2'd0,
    MODE_REDUCE32 = 2'd1,
    MODE_FREEZE   = 2'd2,
    MODE_PASS     = 2'd3
  } mode_e;

  // The rounding add is done one bit wider so INT_MAX + 2^22 cannot wrap.
  function automatic logic [COEFF_W-1:0] reduce32(input logic [COEFF_W-1:0] a);
    logic signed [COEFF_W:0] t;
    t = ($signed({a[COEFF_W-1], a}) + ROUND) >>> 23;
    return a - t[COEFF_W-1:0] * QW;
  endfunction

  function automatic logic [COEFF_W-1:0] caddq(input logic [COEFF_W-1:0] a);
    return a + (a[COEFF_W-1] ? QW : '0);
  endfunction

  logic [BEAT_W-1:0] beat_cnt;
  logic [IDX_W-1:0]  poly_cnt;
  mode_e             mode_lat;

  logic              v1;
  logic [DW-1:0]     d1;
  mode_e             mode1;
  logic [IDX_W-1:0]  idx1;
  logic              last1;

  logic              s1_adv, s2_adv, in_fire;
  logic              first_beat, beat_wrap, last_beat;
  mode_e             in_mode;
  logic [DW-1:0]     r1, r2;

  assign s2_adv     = !out_valid || out_ready;
  assign s1_adv     = !v1 || s2_adv;
  assign in_ready   = s1_adv && !rst;
  assign in_fire    = in_valid && in_ready;
  assign first_beat = (beat_cnt == '0) && (poly_cnt == '0);
  assign beat_wrap  = (beat_cnt == BEAT_W'(BPP - 1));
  assign last_beat  = beat_wrap && (poly_cnt == IDX_W'(K - 1));
  // The first beat of a vector uses cfg_mode directly, later beats the latched copy.
  assign in_mode    = first_beat ? mode_e'(cfg_mode) : mode_lat;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    r1 = in_data;
    r2 = d1;
    for (int i = 0; i < LANES; i++) begin
      if (in_mode == MODE_REDUCE32 || in_mode == MODE_FREEZE)
        r1[i*COEFF_W +: COEFF_W] = reduce32(in_data[i*COEFF_W +: COEFF_W]);
      if (mode1 == MODE_CADDQ || mode1 == MODE_FREEZE)
        r2[i*COEFF_W +: COEFF_W] = caddq(d1[i*COEFF_W +: COEFF_W]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt     <= '0;
      poly_cnt     <= '0;
      mode_lat     <= MODE_CADDQ;
      v1           <= 1'b0;
      d1           <= '0;
      mode1        <= MODE_CADDQ;
      idx1         <= '0;
      last1        <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_poly_idx <= '0;
      out_last     <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (in_fire) begin
        if (first_beat) mode_lat <= in_mode;
        if (beat_wrap) begin
          beat_cnt <= '0;
          poly_cnt <= last_beat ? '0 : poly_cnt + IDX_W'(1);
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end

      if (s1_adv) begin
        v1 <= in_fire;
        if (in_fire) begin
          d1    <= r1;
          mode1 <= in_mode;
          idx1  <= poly_cnt;
          last1 <= last_beat;
        end
      end

      if (s2_adv) begin
        out_valid <= v1;
        if (v1) begin
          out_data     <= r2;
          out_poly_idx <= idx1;
          out_last     <= last1;
        end
      end

      done <= out_valid && out_ready && out_last;
    end
  end

endmodule
